// File: rtl/vend_credit_fsm.sv
// Coin-credit vending controller: accumulates nickel/dime/quarter credit, handshakes a vend
// with the dispenser and pays change or refunds as a train of one-cycle nickel pulses.
module vend_credit_fsm #(
  parameter int unsigned PRICE      = 3,
  parameter int unsigned CW         = 5,
  parameter int unsigned MAX_CREDIT = 20,
  parameter int unsigned VEND_TO    = 8
) (
  input  logic          clock,
  input  logic          clear,
  input  logic [1:0]    coin,
  input  logic          cancel,
  input  logic          vend_ack,
  output logic          vend_req,
  output logic          change_nickel,
  output logic [CW-1:0] credit,
  output logic          coin_reject,
  output logic          vend_done,
  output logic          timeout_err,
  output logic [1:0]    state
);

  localparam int unsigned SW = CW + 1;
  localparam int unsigned TW = $clog2(VEND_TO + 1);

  localparam logic [SW-1:0] MaxSum    = SW'(MAX_CREDIT);
  localparam logic [SW-1:0] PriceWide = SW'(PRICE);
  localparam logic [CW-1:0] PriceCr   = CW'(PRICE);
  localparam logic [TW-1:0] ToLast    = TW'(VEND_TO - 1);

  typedef enum logic [1:0] {
    StCollect = 2'b00,
    StVend    = 2'b01,
    StReturn  = 2'b10
  } state_e;

  state_e        r_state, w_state_next;
  logic [CW-1:0] r_credit, w_credit_next;
  logic [TW-1:0] r_cnt, w_cnt_next;
  logic          r_reject, w_reject_next;
  logic          r_done, w_done_next;
  logic          r_timeout, w_timeout_next;
  logic [SW-1:0] w_value;
  logic [SW-1:0] w_sum;

  always_comb begin
    w_value = '0;
    unique case (coin)
      2'b01:   w_value = SW'(1);
      2'b11:   w_value = SW'(2);
      2'b10:   w_value = SW'(5);
      default: w_value = '0;
    endcase
  end

  // One bit wider than the register so the overflow compare can never wrap.
  assign w_sum = {1'b0, r_credit} + w_value;

  always_comb begin
    w_state_next   = r_state;
    w_credit_next  = r_credit;
    w_cnt_next     = '0;
    w_reject_next  = 1'b0;
    w_done_next    = 1'b0;
    w_timeout_next = 1'b0;
    unique case (r_state)
      StCollect: begin
        if (cancel && (r_credit != '0)) begin
          w_state_next  = StReturn;
          w_reject_next = (coin != 2'b00);
        end else if (coin != 2'b00) begin
          if (w_sum <= MaxSum) begin
            w_credit_next = w_sum[CW-1:0];
            if (w_sum >= PriceWide) begin
              w_state_next = StVend;
            end
          end else begin
            w_reject_next = 1'b1;
          end
        end
      end
      StVend: begin
        w_reject_next = (coin != 2'b00);
        // Ack takes priority over a timeout landing on the same edge.
        if (vend_ack) begin
          w_credit_next = r_credit - PriceCr;
          w_done_next   = 1'b1;
          w_state_next  = (r_credit != PriceCr) ? StReturn : StCollect;
        end else if (r_cnt == ToLast) begin
          w_state_next   = StReturn;
          w_timeout_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StReturn: begin
        w_reject_next = (coin != 2'b00);
        if (r_credit <= CW'(1)) begin
          w_credit_next = '0;
          w_state_next  = StCollect;
        end else begin
          w_credit_next = r_credit - 1'b1;
        end
      end
      default: begin
        w_state_next  = StCollect;
        w_credit_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= StCollect;
      r_credit  <= '0;
      r_cnt     <= '0;
      r_reject  <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_credit  <= w_credit_next;
      r_cnt     <= w_cnt_next;
      r_reject  <= w_reject_next;
      r_done    <= w_done_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign vend_req      = (r_state == StVend);
  assign change_nickel = (r_state == StReturn);
  assign credit        = r_credit;
  assign coin_reject   = r_reject;
  assign vend_done     = r_done;
  assign timeout_err   = r_timeout;
  assign state         = r_state;

endmodule

// File: doc/vend_credit_fsm.md
# vend_credit_fsm

Parametrised coin-credit vending controller, the next generation of the 15-cent nickel/dime vending FSM. It accumulates nickels, dimes and quarters into a binary credit register and handshakes a vend with the product dispenser. It returns change or refunds as a train of one-cycle nickel pulses, with cancel, overflow rejection and dispenser timeout. It sits between the coin acceptor and the dispenser/change hopper.

## Interface
Parameters:
- `PRICE`, default 3: item price in nickels (3 = 15 cents); 1 ≤ PRICE ≤ MAX_CREDIT.
- `CW`, default 5: credit register width; MAX_CREDIT < 2^CW.
- `MAX_CREDIT`, default 20: largest credit held, in nickels.
- `VEND_TO`, default 8: cycles in VEND without `vend_ack` before timeout; ≥ 2.

Ports:
- `clock`, in, 1: single clock; all state changes on its rising edge.
- `clear`, in, 1: synchronous, active-high reset.
- `coin`, in, 2: coin sampled each edge. 00 none, 01 nickel (+1), 11 dime (+2), 10 quarter (+5).
- `cancel`, in, 1: refund request, level-sampled.
- `vend_ack`, in, 1: dispenser accepted the vend.
- `vend_req`, out, 1: vend request, registered.
- `change_nickel`, out, 1: one nickel returned per high cycle.
- `credit`, out, CW: current credit in nickels.
- `coin_reject`, out, 1: one-cycle pulse; the coin sampled at the previous edge was rejected.
- `vend_done`, out, 1: one-cycle pulse after an accepted `vend_ack`.
- `timeout_err`, out, 1: one-cycle pulse after a VEND timeout.
- `state`, out, 2: debug state code. 00 COLLECT, 01 VEND, 10 RETURN.

## Operation
Reset:
- `clear` sampled high at an edge sets state COLLECT and zeroes `credit` and the timeout counter.
- All outputs are 0 after that edge. `clear` overrides every other input, including mid-RETURN and mid-VEND.

Pulse outputs: `coin_reject`, `vend_done` and `timeout_err` are registered and high exactly one cycle.

COLLECT:
- Valid coin, no cancel, credit+value ≤ MAX_CREDIT: credit ← credit+value.
  - If the new credit ≥ PRICE, go to VEND.
  - Otherwise stay in COLLECT.
- Coin with credit+value > MAX_CREDIT: credit unchanged, `coin_reject` pulse.
- `cancel` with credit > 0: go to RETURN. Any coin sampled at the same edge is rejected.
- `cancel` with credit = 0: ignored. A coin at the same edge is accepted normally.

VEND:
- `vend_req` = 1 throughout. Coins are rejected and `cancel` is ignored.
- `vend_ack` high at an edge:
  - credit ← credit − PRICE; `vend_done` pulse; timeout counter cleared.
  - Go to RETURN if the remainder > 0, else to COLLECT.
- Counter counts edges spent in VEND without ack. At the VEND_TO-th such edge: go to RETURN with the full credit kept, `timeout_err` pulse.
- Ack and timeout on the same edge: ack wins, no timeout.

RETURN:
- `change_nickel` = 1 and credit decrements by 1 each edge.
- At the edge where credit = 1, credit becomes 0 and state goes to COLLECT. The number of `change_nickel` cycles therefore equals the credit on entry.
- Coins are rejected; `cancel` is ignored.

Width rules:
- All arithmetic is unsigned, CW bits.
- The sum credit+value is computed CW+1 bits wide before the MAX_CREDIT compare, so it cannot wrap.

## Timing
- Moore outputs: `vend_req`, `change_nickel` and `state` are decoded from the registered state. `credit` is the register itself.
- A coin completing the price at edge k gives `credit` and `vend_req` high from edge k. Minimum ack is then at edge k+1.
- An ack at edge m drops `vend_req` and raises `vend_done` after edge m. The first change nickel is the cycle after edge m.
- Reject pulse appears in the cycle after the rejected coin's edge.
- Back-to-back coins in consecutive cycles are all accepted.
- A coin on the edge that enters VEND counts. A coin on the edge that leaves RETURN is rejected.

## Test plan
- PRICE=3: nickel, nickel, nickel on consecutive edges -> credit 1,2,3, `vend_req`=1. Ack one cycle later -> `vend_done` pulse, credit 0, COLLECT, `change_nickel` never high.
- PRICE=3: dime, dime -> credit 4, VEND. Ack -> `change_nickel` high exactly 1 cycle, credit 0.
- PRICE=3: single quarter -> credit 5, VEND. Ack -> `change_nickel` high 2 consecutive cycles, then COLLECT. A dime during VEND -> `coin_reject` pulse, credit unchanged.
- Nickel, then cancel -> 1 change cycle, credit 0. Separately, dime with cancel on the same edge at credit 1 -> `coin_reject`, 1 change cycle.
- PRICE=12, MAX_CREDIT=14: two quarters (credit 10), then a quarter -> rejected, credit stays 10. A nickel then a dime -> credit 13, VEND.
- VEND_TO=8, no ack -> `timeout_err` after the 8th VEND edge, full credit returned as nickels. Ack on the 8th edge -> normal vend instead. `clear` asserted mid-RETURN -> next cycle all outputs 0, state 00.
